// File: rtl/relay_sequencer_pkg.sv
// Shared constants, parameter defaults and FSM state encoding for relay_sequencer.
package relay_sequencer_pkg;

    localparam logic low_p  = 1'b0;
    localparam logic high_p = 1'b1;

    localparam int channels_def_p       = 4;
    localparam int max_active_def_p     = 2;
    localparam int gap_cycles_def_p     = 1000;
    localparam int min_on_cycles_def_p  = 5000;
    localparam int counter_length_def_p = 16;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } seq_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relay_rr_pick.sv
// Combinational round-robin picker: lowest index at or after ptr (wrapping) whose mask bit is set.
module relay_rr_pick #(
    parameter int channels_p = 4,
    parameter int idx_w_p    = 2
) (
    input  logic [channels_p-1:0] mask,
    input  logic [idx_w_p-1:0]    ptr,
    output logic                  valid,
    output logic [idx_w_p-1:0]    index,
    output logic [channels_p-1:0] onehot
);

    logic [idx_w_p-1:0] cand;

    // Scan from farthest offset down so the nearest candidate to ptr is the last one written.
    always_comb begin
        valid  = 1'b0;
        index  = '0;
        cand   = '0;
        onehot = '0;
        for (int k = channels_p - 1; k >= 0; k--) begin
            cand = idx_w_p'((int'(ptr) + k) % channels_p);
            if (mask[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
        if (valid) begin
            onehot[index] = 1'b1;
        end
    end

endmodule

// File: rtl/relay_sequencer.sv
// Relay coil sequencer: one toggle per guard gap, active-relay cap, minimum on-time.
// Optional macro RELAY_SEQ_FORCE_OFF_EN adds Force_off_i to shed all relays one per gap.
//
// state | meaning
// IDLE  | waiting for an eligible change; toggles the winner on the next edge
// GAP   | guard gap after a toggle, Busy_o high, gap counter running down to 0
module relay_sequencer
    import relay_sequencer_pkg::*;
#(
    parameter int channels_p       = channels_def_p,
    parameter int max_active_p     = max_active_def_p,
    parameter int gap_cycles_p     = gap_cycles_def_p,
    parameter int min_on_cycles_p  = min_on_cycles_def_p,
    parameter int counter_length_p = counter_length_def_p
) (
    input  logic                  Clk_i,
    input  logic                  Reset_i,
    input  logic [channels_p-1:0] Request_i,
    output logic [channels_p-1:0] Relay_o,
    output logic                  Busy_o,
    output logic [channels_p-1:0] Denied_o
`ifdef RELAY_SEQ_FORCE_OFF_EN
    ,
    input  logic                  Force_off_i
`endif
);

    localparam int idx_w = idx_width(channels_p);
    localparam int cnt_w = $clog2(channels_p + 1);

    localparam logic [cnt_w-1:0]            max_active_c = cnt_w'(max_active_p);
    localparam logic [counter_length_p-1:0] gap_load_c   = counter_length_p'(gap_cycles_p - 1);
    localparam logic [counter_length_p-1:0] min_on_c     = counter_length_p'(min_on_cycles_p);
    localparam logic [counter_length_p-1:0] one_c        = counter_length_p'(1);
    localparam logic [idx_w-1:0]            last_idx_c   = idx_w'(channels_p - 1);

    seq_state_e                 state_q, state_d;
    logic [channels_p-1:0]      relay_q, relay_d;
    logic [channels_p-1:0]      denied_q, denied_d;
    logic [idx_w-1:0]           ptr_q, ptr_d;
    logic [counter_length_p-1:0] gap_q, gap_d;
    logic [counter_length_p-1:0] hold_q [channels_p];

    logic                       force_off;
    logic [cnt_w-1:0]           active_cnt;
    logic [channels_p-1:0]      pending, hold_done, off_elig, on_elig;
    logic                       off_valid, on_valid;
    logic [idx_w-1:0]           off_idx, on_idx, win_idx;
    logic [channels_p-1:0]      off_onehot, on_onehot, win_onehot;

`ifdef RELAY_SEQ_FORCE_OFF_EN
    assign force_off = Force_off_i;
`else
    assign force_off = low_p;
`endif

    always_comb begin
        active_cnt = '0;
        for (int i = 0; i < channels_p; i++) begin
            active_cnt = active_cnt + cnt_w'(relay_q[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < channels_p; i++) begin
            hold_done[i] = (hold_q[i] >= min_on_c);
        end
    end

    assign pending = Request_i ^ relay_q;

    // Force-off sheds every energised relay and blocks any new energisation.
    assign off_elig = force_off ? relay_q : (pending & relay_q & hold_done);
    assign on_elig  = force_off ? '0
                    : (pending & ~relay_q & {channels_p{active_cnt < max_active_c}});

    relay_rr_pick #(.channels_p(channels_p), .idx_w_p(idx_w)) u_pick_off (
        .mask   (off_elig),
        .ptr    (ptr_q),
        .valid  (off_valid),
        .index  (off_idx),
        .onehot (off_onehot)
    );

    relay_rr_pick #(.channels_p(channels_p), .idx_w_p(idx_w)) u_pick_on (
        .mask   (on_elig),
        .ptr    (ptr_q),
        .valid  (on_valid),
        .index  (on_idx),
        .onehot (on_onehot)
    );

    assign win_idx    = off_valid ? off_idx    : on_idx;
    assign win_onehot = off_valid ? off_onehot : on_onehot;

    always_comb begin
        state_d = state_q;
        relay_d = relay_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (off_valid || on_valid) begin
                    relay_d = relay_q ^ win_onehot;
                    ptr_d   = (win_idx == last_idx_c) ? '0 : win_idx + idx_w'(1);
                    gap_d   = gap_load_c;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - one_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign denied_d = force_off ? '0
                    : (Request_i & ~relay_q & {channels_p{active_cnt == max_active_c}});

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q  <= IDLE;
            relay_q  <= '0;
            denied_q <= '0;
            ptr_q    <= '0;
            gap_q    <= '0;
            for (int i = 0; i < channels_p; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            relay_q  <= relay_d;
            denied_q <= denied_d;
            ptr_q    <= ptr_d;
            gap_q    <= gap_d;
            for (int i = 0; i < channels_p; i++) begin
                if (relay_d[i] && !relay_q[i]) begin
                    hold_q[i] <= '0;
                end else if (relay_q[i] && !hold_done[i]) begin
                    hold_q[i] <= hold_q[i] + one_c;
                end else if (!relay_q[i]) begin
                    hold_q[i] <= '0;
                end
            end
        end
    end

    assign Relay_o  = relay_q;
    assign Busy_o   = (state_q == GAP) ? high_p : low_p;
    assign Denied_o = denied_q;

endmodule

// File: tb/tb_relay_sequencer.sv
// Scoreboard bench for relay_sequencer: directed scenarios plus random requests vs a behavioural model.
module tb_relay_sequencer;

    localparam int CH    = 4;
    localparam int MAXA  = 2;
    localparam int GAPC  = 4;
    localparam int MINON = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] req = '0;
    logic          force_off = 1'b0;
    logic [CH-1:0] relay, denied;
    logic          busy;

    always #5 clk = ~clk;

    relay_sequencer #(
        .channels_p(CH), .max_active_p(MAXA), .gap_cycles_p(GAPC),
        .min_on_cycles_p(MINON), .counter_length_p(16)
    ) dut (
        .Clk_i     (clk),
        .Reset_i   (rst),
        .Request_i (req),
        .Relay_o   (relay),
        .Busy_o    (busy),
        .Denied_o  (denied)
`ifdef RELAY_SEQ_FORCE_OFF_EN
        ,
        .Force_off_i (force_off)
`endif
    );

    typedef struct packed {
        logic [CH-1:0] relay;
        logic          busy;
        logic [CH-1:0] denied;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_vec(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: relays, hold times, round-robin start and remaining lockout cycles.
    logic [CH-1:0] m_relay = '0;
    logic [CH-1:0] m_denied = '0;
    int            m_hold [CH];
    int            m_ptr = 0;
    int            m_lock = 0;

    task automatic model_step(input logic [CH-1:0] r, input logic rs, input logic f);
        logic [CH-1:0] old;
        int cnt, win, c;
        exp_t e;
        if (rs) begin
            m_relay = '0; m_denied = '0; m_ptr = 0; m_lock = 0;
            for (int i = 0; i < CH; i++) m_hold[i] = 0;
        end else begin
            old = m_relay;
            cnt = $countones(old);
            win = -1;
            m_denied = (f || cnt != MAXA) ? '0 : (r & ~old);
            if (m_lock == 0) begin
                for (int k = 0; k < CH; k++) begin
                    c = (m_ptr + k) % CH;
                    if (win < 0 && old[c] && (f || (!r[c] && m_hold[c] >= MINON))) win = c;
                end
                for (int k = 0; k < CH; k++) begin
                    c = (m_ptr + k) % CH;
                    if (win < 0 && !f && !old[c] && r[c] && cnt < MAXA) win = c;
                end
                if (win >= 0) begin
                    m_relay[win] = ~m_relay[win];
                    m_ptr = (win + 1) % CH;
                    m_lock = GAPC;
                end
            end else begin
                m_lock--;
            end
            for (int i = 0; i < CH; i++) begin
                if (m_relay[i] && !old[i]) m_hold[i] = 0;
                else if (old[i]) m_hold[i] = (m_hold[i] + 1 > MINON) ? MINON : m_hold[i] + 1;
                else m_hold[i] = 0;
            end
        end
        e.relay = m_relay;
        e.busy = (m_lock > 0);
        e.denied = m_denied;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [CH-1:0] r, input logic rs, input logic f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = r; rst = rs; force_off = f;
            model_step(r, rs, f);
        end
    endtask

    // Monitor: compares every cycle, and independently checks toggle spacing and single-bit changes.
    exp_t          mon_e;
    int            cyc = 0;
    int            last_toggle = -100;
    logic [CH-1:0] prev_relay = '0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_vec("relay", relay, mon_e.relay);
            check_vec("busy", {3'b000, busy}, {3'b000, mon_e.busy});
            check_vec("denied", denied, mon_e.denied);
            if (rst) begin
                last_toggle = -100;
            end else if (relay !== prev_relay) begin
                check_int("one_bit_toggle", $countones(relay ^ prev_relay), 1);
                total++;
                if (cyc - last_toggle < GAPC + 1) begin
                    bad++;
                    $display("FAIL toggle_spacing at t=%0t: got %0d cycles required >= %0d",
                             $time, cyc - last_toggle, GAPC + 1);
                end
                last_toggle = cyc;
            end
            prev_relay = relay;
        end
    end

    initial begin
        logic [CH-1:0] rr;
        logic rs, f;
        int n;
        for (int i = 0; i < CH; i++) m_hold[i] = 0;

        // Reset held with all requests, then release.
        drive(4'b1111, 1'b1, 1'b0, 3);
        drive(4'b1111, 1'b0, 1'b0, 20);

        // Simultaneous pair from idle.
        drive(4'b0000, 1'b1, 1'b0, 2);
        drive(4'b0000, 1'b0, 1'b0, 3);
        drive(4'b0011, 1'b0, 1'b0, 20);

        // Early drop: relay held until minimum on-time.
        drive(4'b0000, 1'b1, 1'b0, 2);
        drive(4'b0001, 1'b0, 1'b0, 4);
        drive(4'b0000, 1'b0, 1'b0, 20);

        // Swap at the cap: ch0 off first, then ch2 on.
        drive(4'b0000, 1'b1, 1'b0, 2);
        drive(4'b0011, 1'b0, 1'b0, 25);
        drive(4'b0110, 1'b0, 1'b0, 20);

        // Pointer wrap after a grant to ch3.
        drive(4'b0000, 1'b1, 1'b0, 2);
        drive(4'b1000, 1'b0, 1'b0, 6);
        drive(4'b1101, 1'b0, 1'b0, 20);

        // Reset mid-gap with two relays on.
        drive(4'b0000, 1'b1, 1'b0, 2);
        drive(4'b0011, 1'b0, 1'b0, 8);
        drive(4'b0011, 1'b1, 1'b0, 1);
        drive(4'b0011, 1'b0, 1'b0, 4);

`ifdef RELAY_SEQ_FORCE_OFF_EN
        // Force-off sheds both relays despite short hold.
        drive(4'b0000, 1'b1, 1'b0, 2);
        drive(4'b0011, 1'b0, 1'b0, 8);
        drive(4'b0011, 1'b0, 1'b1, 12);
        drive(4'b0011, 1'b0, 1'b0, 20);
`endif

        // Randomised segments.
        for (int s = 0; s < 150; s++) begin
            rr = CH'($urandom);
            rs = ($urandom_range(0, 40) == 0);
            f = 1'b0;
`ifdef RELAY_SEQ_FORCE_OFF_EN
            f = ($urandom_range(0, 7) == 0);
`endif
            n = rs ? $urandom_range(1, 3) : $urandom_range(1, 30);
            drive(rr, rs, f, n);
        end

        @(negedge clk);
        @(negedge clk);
        check_int("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
